// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register-file writeback arbiter:
//   DATA_W_DEF / ADDR_W_DEF : default register data and index widths
//   REG_ZERO                : index of the hard-wired zero register
//   grant_t                 : arbiter grant encoding (none / A / B)
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_A    = 2'd1,
        GNT_B    = 2'd2
    } grant_t;

endpackage

// File: rtl/wb_slot.sv
// -----------------------------------------------------------------------------
// wb_slot
// One-entry writeback holding buffer behind a valid/ready handshake.
// Ports:
//   clock, reset         : clock, synchronous active-high reset
//   in_valid / in_ready  : requester handshake
//   in_reg / in_data     : destination register and data to capture
//   granted              : arbiter drains this entry in the current cycle
//   full                 : an entry is held
//   fill                 : a transfer happens at the coming edge
//   slot_reg / slot_data : held destination register and data
// -----------------------------------------------------------------------------
module wb_slot
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_reg,
    input  logic [DATA_W-1:0] in_data,
    input  logic              granted,
    output logic              full,
    output logic              fill,
    output logic [ADDR_W-1:0] slot_reg,
    output logic [DATA_W-1:0] slot_data
);

    logic              full_r;
    logic [ADDR_W-1:0] reg_r;
    logic [DATA_W-1:0] data_r;
    logic              ready_s;
    logic              fill_s;

    // Ready when empty, or when the held entry leaves this cycle so it can be refilled.
    always_comb begin
        ready_s = 1'b0;
        if (reset) begin
            ready_s = 1'b0;
        end else begin
            ready_s = ~full_r | granted;
        end
        fill_s = in_valid & ready_s;
    end

    // Buffer state: capture only on transfer, free on grant, otherwise hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            full_r <= 1'b0;
            reg_r  <= {ADDR_W{1'b0}};
            data_r <= {DATA_W{1'b0}};
        end else if (fill_s) begin
            full_r <= 1'b1;
            reg_r  <= in_reg;
            data_r <= in_data;
        end else if (granted) begin
            full_r <= 1'b0;
        end
    end

    assign in_ready  = ready_s;
    assign fill      = fill_s;
    assign full      = full_r;
    assign slot_reg  = reg_r;
    assign slot_data = data_r;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the register file's single write port between requester A (ALU
// result) and requester B (memory load). Each requester owns a one-entry
// buffer; buffered entries drain oldest-first, round-robin on a tie.
// Optional feature: define WB_BYPASS_EN to add fwd_data1/fwd_data2, the
// youngest pending value for each snooped read address.
// Ports:
//   clock, reset                       : clock, synchronous active-high reset
//   a_valid/a_ready/a_reg/a_data       : requester A write handshake
//   b_valid/b_ready/b_reg/b_data       : requester B write handshake
//   RegWrite/Write_reg/Write_data      : registered register-file write port
//   Read_reg1/Read_reg2                : snooped read addresses
//   pend1/pend2                        : pending write to the read address
//   fwd_data1/fwd_data2                : (WB_BYPASS_EN) youngest pending data
//   idle                               : both buffers empty and RegWrite low
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W        = DATA_W_DEF,
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter bit ZERO_SUPPRESS = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] Write_reg,
    output logic [DATA_W-1:0] Write_data,
    input  logic [ADDR_W-1:0] Read_reg1,
    input  logic [ADDR_W-1:0] Read_reg2,
    output logic              pend1,
    output logic              pend2,
`ifdef WB_BYPASS_EN
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2,
`endif
    output logic              idle
);

    grant_t            gnt_s;
    logic              gnt_a_s;
    logic              gnt_b_s;
    logic              a_full_s;
    logic              b_full_s;
    logic              a_fill_s;
    logic              b_fill_s;
    logic [ADDR_W-1:0] a_reg_s;
    logic [ADDR_W-1:0] b_reg_s;
    logic [DATA_W-1:0] a_data_s;
    logic [DATA_W-1:0] b_data_s;
    logic [ADDR_W-1:0] gnt_reg_s;
    logic [DATA_W-1:0] gnt_data_s;
    logic              suppress_s;
    logic              age_valid_r;
    logic              older_b_r;
    logic              rr_b_r;
    logic              reg_write_r;
    logic [ADDR_W-1:0] write_reg_r;
    logic [DATA_W-1:0] write_data_r;
    logic [2:0]        hit1_s;
    logic [2:0]        hit2_s;
    logic              pend1_s;
    logic              pend2_s;

    wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_a (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (a_valid),
        .in_ready  (a_ready),
        .in_reg    (a_reg),
        .in_data   (a_data),
        .granted   (gnt_a_s),
        .full      (a_full_s),
        .fill      (a_fill_s),
        .slot_reg  (a_reg_s),
        .slot_data (a_data_s)
    );

    wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_b (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (b_valid),
        .in_ready  (b_ready),
        .in_reg    (b_reg),
        .in_data   (b_data),
        .granted   (gnt_b_s),
        .full      (b_full_s),
        .fill      (b_fill_s),
        .slot_reg  (b_reg_s),
        .slot_data (b_data_s)
    );

    // Grant selection: a lone full buffer wins; with both full the older wins, else round-robin.
    always_comb begin
        gnt_s = GNT_NONE;
        if (a_full_s && b_full_s) begin
            if (age_valid_r) begin
                gnt_s = older_b_r ? GNT_B : GNT_A;
            end else begin
                gnt_s = rr_b_r ? GNT_B : GNT_A;
            end
        end else if (a_full_s) begin
            gnt_s = GNT_A;
        end else if (b_full_s) begin
            gnt_s = GNT_B;
        end else begin
            gnt_s = GNT_NONE;
        end
    end

    // Granted entry contents and zero-register suppression.
    always_comb begin
        gnt_a_s    = 1'b0;
        gnt_b_s    = 1'b0;
        gnt_reg_s  = {ADDR_W{1'b0}};
        gnt_data_s = {DATA_W{1'b0}};
        case (gnt_s)
            GNT_A: begin
                gnt_a_s    = 1'b1;
                gnt_reg_s  = a_reg_s;
                gnt_data_s = a_data_s;
            end
            GNT_B: begin
                gnt_b_s    = 1'b1;
                gnt_reg_s  = b_reg_s;
                gnt_data_s = b_data_s;
            end
            default: begin
                gnt_a_s    = 1'b0;
                gnt_b_s    = 1'b0;
            end
        endcase
        suppress_s = ZERO_SUPPRESS && (gnt_reg_s == ADDR_W'(REG_ZERO));
    end

    // Age flag and round-robin pointer. A fill behind a stalled full entry marks that
    // entry older; this takes precedence over clearing so a refill in the same cycle
    // the older entry drains still records the new ordering.
    always_ff @(posedge clock) begin
        if (reset) begin
            age_valid_r <= 1'b0;
            older_b_r   <= 1'b0;
            rr_b_r      <= 1'b0;
        end else begin
            if (a_full_s && b_full_s && !age_valid_r) begin
                rr_b_r <= ~rr_b_r;
            end
            if (a_fill_s && b_full_s && !gnt_b_s) begin
                age_valid_r <= 1'b1;
                older_b_r   <= 1'b1;
            end else if (b_fill_s && a_full_s && !gnt_a_s) begin
                age_valid_r <= 1'b1;
                older_b_r   <= 1'b0;
            end else if (age_valid_r && ((older_b_r && gnt_b_s) || (!older_b_r && gnt_a_s))) begin
                age_valid_r <= 1'b0;
            end
        end
    end

    // Registered write port; address and data hold between strobes.
    always_ff @(posedge clock) begin
        if (reset) begin
            reg_write_r  <= 1'b0;
            write_reg_r  <= {ADDR_W{1'b0}};
            write_data_r <= {DATA_W{1'b0}};
        end else if ((gnt_s != GNT_NONE) && !suppress_s) begin
            reg_write_r  <= 1'b1;
            write_reg_r  <= gnt_reg_s;
            write_data_r <= gnt_data_s;
        end else begin
            reg_write_r  <= 1'b0;
        end
    end

    // Hazard lookup; bit 0 = buffer A, bit 1 = buffer B, bit 2 = write-port stage.
    always_comb begin
        hit1_s[0] = a_full_s && (a_reg_s == Read_reg1);
        hit1_s[1] = b_full_s && (b_reg_s == Read_reg1);
        hit1_s[2] = reg_write_r && (write_reg_r == Read_reg1);
        hit2_s[0] = a_full_s && (a_reg_s == Read_reg2);
        hit2_s[1] = b_full_s && (b_reg_s == Read_reg2);
        hit2_s[2] = reg_write_r && (write_reg_r == Read_reg2);
        pend1_s   = (Read_reg1 != ADDR_W'(REG_ZERO)) && (|hit1_s);
        pend2_s   = (Read_reg2 != ADDR_W'(REG_ZERO)) && (|hit2_s);
    end

`ifdef WB_BYPASS_EN
    logic [DATA_W-1:0] fwd1_s;
    logic [DATA_W-1:0] fwd2_s;

    // Youngest pending value per read port. With both buffers full the granted one
    // is the older, so the non-granted buffer holds the youngest value.
    always_comb begin
        fwd1_s = {DATA_W{1'b0}};
        fwd2_s = {DATA_W{1'b0}};
        if (!pend1_s) begin
            fwd1_s = {DATA_W{1'b0}};
        end else if (hit1_s[0] && hit1_s[1]) begin
            fwd1_s = gnt_a_s ? b_data_s : a_data_s;
        end else if (hit1_s[0]) begin
            fwd1_s = a_data_s;
        end else if (hit1_s[1]) begin
            fwd1_s = b_data_s;
        end else begin
            fwd1_s = write_data_r;
        end
        if (!pend2_s) begin
            fwd2_s = {DATA_W{1'b0}};
        end else if (hit2_s[0] && hit2_s[1]) begin
            fwd2_s = gnt_a_s ? b_data_s : a_data_s;
        end else if (hit2_s[0]) begin
            fwd2_s = a_data_s;
        end else if (hit2_s[1]) begin
            fwd2_s = b_data_s;
        end else begin
            fwd2_s = write_data_r;
        end
    end

    assign fwd_data1 = fwd1_s;
    assign fwd_data2 = fwd2_s;
`endif

    assign RegWrite   = reg_write_r;
    assign Write_reg  = write_reg_r;
    assign Write_data = write_data_r;
    assign pend1      = pend1_s;
    assign pend2      = pend2_s;
    assign idle       = ~a_full_s & ~b_full_s & ~reg_write_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Self-checking bench: a vector table of single writes plus hand-written
// multi-cycle sequences; expected writes are queued when stimulus is accepted
// and compared, in order, whenever the DUT strobes RegWrite.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          a_valid = 1'b0;
    logic          a_ready;
    logic [AW-1:0] a_reg = 5'd0;
    logic [DW-1:0] a_data = 32'd0;
    logic          b_valid = 1'b0;
    logic          b_ready;
    logic [AW-1:0] b_reg = 5'd0;
    logic [DW-1:0] b_data = 32'd0;
    logic          RegWrite;
    logic [AW-1:0] Write_reg;
    logic [DW-1:0] Write_data;
    logic [AW-1:0] Read_reg1 = 5'd0;
    logic [AW-1:0] Read_reg2 = 5'd0;
    logic          pend1;
    logic          pend2;
    logic          idle;
`ifdef WB_BYPASS_EN
    logic [DW-1:0] fwd_data1;
    logic [DW-1:0] fwd_data2;
`endif

    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .ZERO_SUPPRESS(1'b1)) dut (
        .clock      (clock),
        .reset      (reset),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_reg      (a_reg),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_reg      (b_reg),
        .b_data     (b_data),
        .RegWrite   (RegWrite),
        .Write_reg  (Write_reg),
        .Write_data (Write_data),
        .Read_reg1  (Read_reg1),
        .Read_reg2  (Read_reg2),
        .pend1      (pend1),
        .pend2      (pend2),
`ifdef WB_BYPASS_EN
        .fwd_data1  (fwd_data1),
        .fwd_data2  (fwd_data2),
`endif
        .idle       (idle)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [AW-1:0] rg;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct packed {
        logic          use_b;
        logic [AW-1:0] rg;
        logic [DW-1:0] data;
        logic          exp_write;
        logic          exp_pend;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;
    int   run_len = 0;
    int   max_run = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [AW-1:0] rg, input logic [DW-1:0] data);
        wr_t w;
        w.rg   = rg;
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (idle !== 1'b1 && n < 30) begin
            @(negedge clock);
            #1;
            n++;
        end
        check(name, 64'(idle), 64'd1);
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clock) begin
        wr_t e;
        if (reset === 1'b0 && RegWrite === 1'b1) begin
            run_len = run_len + 1;
            if (run_len > max_run) max_run = run_len;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual_reg=%0d actual_data=%0h required=no_write",
                         Write_reg, Write_data);
            end else begin
                e = exp_q.pop_front();
                check("sb_write_reg", 64'(Write_reg), 64'(e.rg));
                check("sb_write_data", 64'(Write_data), 64'(e.data));
            end
        end else begin
            run_len = 0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int na;
        int nb;
        vec_t v;

        vecs[0] = '{use_b: 1'b0, rg: 5'd5,  data: 32'h0000_1234, exp_write: 1'b1, exp_pend: 1'b1};
        vecs[1] = '{use_b: 1'b1, rg: 5'd17, data: 32'hDEAD_BEEF, exp_write: 1'b1, exp_pend: 1'b1};
        vecs[2] = '{use_b: 1'b0, rg: 5'd0,  data: 32'hFFFF_FFFF, exp_write: 1'b0, exp_pend: 1'b0};
        vecs[3] = '{use_b: 1'b1, rg: 5'd0,  data: 32'h0000_0055, exp_write: 1'b0, exp_pend: 1'b0};
        vecs[4] = '{use_b: 1'b0, rg: 5'd31, data: 32'hA5A5_0001, exp_write: 1'b1, exp_pend: 1'b1};
        vecs[5] = '{use_b: 1'b1, rg: 5'd1,  data: 32'h0000_0000, exp_write: 1'b1, exp_pend: 1'b1};

        // Reset state
        @(negedge clock);
        @(negedge clock);
        #1;
        check("reset_a_ready", 64'(a_ready), 64'd0);
        check("reset_b_ready", 64'(b_ready), 64'd0);
        check("reset_regwrite", 64'(RegWrite), 64'd0);
        check("reset_write_reg", 64'(Write_reg), 64'd0);
        check("reset_write_data", 64'(Write_data), 64'd0);
        check("reset_idle", 64'(idle), 64'd1);
        reset = 1'b0;
        #1;
        check("post_reset_a_ready", 64'(a_ready), 64'd1);

        // Table: single writes with hazard and latency checks
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            @(negedge clock);
            Read_reg1 = v.rg;
            Read_reg2 = v.rg;
            if (v.use_b) begin
                b_valid = 1'b1; b_reg = v.rg; b_data = v.data;
            end else begin
                a_valid = 1'b1; a_reg = v.rg; a_data = v.data;
            end
            #1;
            check("vec_ready", 64'(v.use_b ? b_ready : a_ready), 64'd1);
            if (v.exp_write) push(v.rg, v.data);
            @(negedge clock);
            a_valid = 1'b0;
            b_valid = 1'b0;
            #1;
            check("vec_pend1_buffered", 64'(pend1), 64'(v.exp_pend));
            check("vec_pend2_buffered", 64'(pend2), 64'(v.exp_pend));
            check("vec_idle_busy", 64'(idle), 64'd0);
`ifdef WB_BYPASS_EN
            check("vec_fwd1", 64'(fwd_data1), v.exp_pend ? 64'(v.data) : 64'd0);
`endif
            @(negedge clock);
            #1;
            check("vec_regwrite", 64'(RegWrite), 64'(v.exp_write));
            check("vec_pend1_port", 64'(pend1), 64'(v.exp_pend));
            @(negedge clock);
            #1;
            check("vec_idle_after", 64'(idle), 64'd1);
            check("vec_pend1_clear", 64'(pend1), 64'd0);
        end

        // Same-cycle tie: pointer at A, so reg 3 first; next tie goes to B first
        @(negedge clock);
        a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h0000_3333;
        b_valid = 1'b1; b_reg = 5'd7; b_data = 32'h0000_7777;
        #1;
        check("tie1_both_ready", 64'({a_ready, b_ready}), 64'd3);
        push(5'd3, 32'h0000_3333);
        push(5'd7, 32'h0000_7777);
        @(negedge clock);
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clock);
        #1;
        check("tie1_first_reg", 64'(Write_reg), 64'd3);
        @(negedge clock);
        #1;
        check("tie1_second_reg", 64'(Write_reg), 64'd7);
        wait_idle("tie1_idle");
        @(negedge clock);
        a_valid = 1'b1; a_reg = 5'd4; a_data = 32'h0000_4444;
        b_valid = 1'b1; b_reg = 5'd6; b_data = 32'h0000_6666;
        push(5'd6, 32'h0000_6666);
        push(5'd4, 32'h0000_4444);
        @(negedge clock);
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clock);
        #1;
        check("tie2_first_reg", 64'(Write_reg), 64'd6);
        wait_idle("tie2_idle");

        // Same destination, A then B one cycle later: 1 then 2, forwarding youngest
        @(negedge clock);
        Read_reg1 = 5'd9;
        a_valid = 1'b1; a_reg = 5'd9; a_data = 32'd1;
        push(5'd9, 32'd1);
        @(negedge clock);
        a_valid = 1'b0;
        b_valid = 1'b1; b_reg = 5'd9; b_data = 32'd2;
        #1;
        check("samereg_b_ready", 64'(b_ready), 64'd1);
        check("samereg_pend1_a", 64'(pend1), 64'd1);
`ifdef WB_BYPASS_EN
        check("samereg_fwd_a", 64'(fwd_data1), 64'd1);
`endif
        push(5'd9, 32'd2);
        @(negedge clock);
        b_valid = 1'b0;
        #1;
        check("samereg_first_data", 64'(Write_data), 64'd1);
`ifdef WB_BYPASS_EN
        check("samereg_fwd_buf_over_port", 64'(fwd_data1), 64'd2);
`endif
        @(negedge clock);
        #1;
        check("samereg_final_data", 64'(Write_data), 64'd2);
        check("samereg_pend1_port", 64'(pend1), 64'd1);
        @(negedge clock);
        #1;
        check("samereg_pend1_clear", 64'(pend1), 64'd0);
        wait_idle("samereg_idle");

        // A streams four writes with B idle
        max_run = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            a_valid = 1'b1; a_reg = 5'(10 + i); a_data = 32'hC000_0000 + 32'(i);
            #1;
            check("streamA_ready", 64'(a_ready), 64'd1);
            push(5'(10 + i), 32'hC000_0000 + 32'(i));
        end
        @(negedge clock);
        a_valid = 1'b0;
        wait_idle("streamA_idle");
        check("streamA_run", 64'(max_run), 64'd4);

        // Both stream three writes: alternate, one write per cycle overall
        max_run = 0;
        na = 0;
        nb = 0;
        for (int k = 0; k < 20 && (na < 3 || nb < 3); k++) begin
            @(negedge clock);
            a_valid = (na < 3); a_reg = 5'(20 + na); a_data = 32'hA000_0000 + 32'(na);
            b_valid = (nb < 3); b_reg = 5'(24 + nb); b_data = 32'hB000_0000 + 32'(nb);
            #1;
            if (a_valid && a_ready) begin
                push(a_reg, a_data);
                na++;
            end
            if (b_valid && b_ready) begin
                push(b_reg, b_data);
                nb++;
            end
        end
        @(negedge clock);
        a_valid = 1'b0; b_valid = 1'b0;
        check("streamAB_accepted", 64'(na + nb), 64'd6);
        wait_idle("streamAB_idle");
        check("streamAB_run", 64'(max_run), 64'd6);

        // Reset while both buffers hold entries: entries dropped, no write issued
        @(negedge clock);
        a_valid = 1'b1; a_reg = 5'd20; a_data = 32'h1111_2020;
        b_valid = 1'b1; b_reg = 5'd21; b_data = 32'h1111_2121;
        @(negedge clock);
        a_valid = 1'b0; b_valid = 1'b0;
        Read_reg1 = 5'd20;
        reset = 1'b1;
        #1;
        check("midreset_a_ready", 64'(a_ready), 64'd0);
        check("midreset_b_ready", 64'(b_ready), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("midreset_regwrite1", 64'(RegWrite), 64'd0);
        check("midreset_idle", 64'(idle), 64'd1);
        check("midreset_pend1", 64'(pend1), 64'd0);
        @(negedge clock);
        #1;
        check("midreset_regwrite2", 64'(RegWrite), 64'd0);

        // After reset the round-robin pointer is back at A
        @(negedge clock);
        a_valid = 1'b1; a_reg = 5'd2; a_data = 32'h0000_0202;
        b_valid = 1'b1; b_reg = 5'd8; b_data = 32'h0000_0808;
        push(5'd2, 32'h0000_0202);
        push(5'd8, 32'h0000_0808);
        @(negedge clock);
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clock);
        #1;
        check("postreset_tie_first", 64'(Write_reg), 64'd2);
        wait_idle("final_idle");
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
